ha_df: RTL and testbench
========================

Name: ha_df

Overview:
- Half-adder datapath: per-lane sum = in1 XOR in2, carry = in1 AND in2.
- Combinational outputs are always live, so the block drops into purely combinational contexts.
- An optional clocked, valid-qualified output stage is included for pipelined users.
- Leaf arithmetic primitive, used under adder and ALU blocks.

Parameters:
- WIDTH, 1, number of independent 1-bit half-adder lanes.
- CNT_W, 16, width of the carry-event counter (used only with HA_DF_CNT_EN).

Ports:
- clk  in  1  single clock for the registered stage.
- rst  in  1  asynchronous, active-high reset.
- in1  in  WIDTH  operand A, bit i = lane i.
- in2  in  WIDTH  operand B.
- in_valid  in  1  qualifies in1/in2 for the registered stage.
- sum  out  WIDTH  combinational in1 ^ in2.
- carry  out  WIDTH  combinational in1 & in2.
- sum_q  out  WIDTH  registered sum.
- carry_q  out  WIDTH  registered carry.
- out_valid  out  1  registered in_valid.
- carry_cnt  out  CNT_W  carry-event count (present only with HA_DF_CNT_EN).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- sum and carry are purely combinational, zero latency.
  - Independent of clk, rst and in_valid.
  - Correct even when clk, rst and in_valid are left unconnected.
- Per lane truth table (in1,in2 -> sum,carry): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- No cross-lane carry: lanes are fully independent.
- Registered stage:
  - out_valid <= in_valid on every rising clk edge.
  - sum_q/carry_q load sum/carry only on edges where in_valid=1; otherwise they hold.
  - Latency 1 cycle from accepted input to sum_q/carry_q/out_valid.
- Reset:
  - rst=1 immediately (asynchronously) forces sum_q=0, carry_q=0, out_valid=0 and carry_cnt=0.
  - Combinational sum/carry are unaffected by reset.
  - Reset asserted mid-stream discards the in-flight result; the first valid after release appears one cycle later.
- X/Z on in_valid is treated as invalid by the verification model; the design never needs to resolve it.
- No backpressure; every valid input is accepted.

Optional Feature:
- Macro HA_DF_CNT_EN.
- Defined:
  - carry_cnt port exists.
  - Increments by 1 on each rising edge where in_valid=1 and any carry lane is 1.
  - Saturates at all-ones and holds; cleared only by rst.
- Undefined: the carry_cnt port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package ha_pkg:
  - default WIDTH and CNT_W constants;
  - lane typedef (logic [WIDTH-1:0]);
  - saturating-increment function.
- One natural sub-module: ha_lane (1-bit sum/carry cell), generated WIDTH times.
- Registers and counter live in the top module.

Test Plan:
- WIDTH=1, clk/rst unconnected: apply 00,01,10,11 at 10 ns steps -> sum/carry = 0/0, 1/0, 1/0, 0/1 within each step.
- WIDTH=8: in1=8'hF0, in2=8'h3C -> sum=8'hCC, carry=8'h30 combinationally.
  - With in_valid=1, sum_q=8'hCC, carry_q=8'h30 and out_valid=1 one edge later.
- Hold: load 11, then drive 01 with in_valid=0 -> sum_q/carry_q stay 0/1; out_valid=0.
- Async reset mid-stream: assert rst between edges -> sum_q, carry_q, out_valid go to 0 before the next edge.
  - Combinational sum/carry still track inputs throughout.
- HA_DF_CNT_EN, CNT_W=4: 20 valid cycles with in1=in2=1 -> carry_cnt reaches 15 and holds.
  - Cycles with in_valid=0 or zero carry leave carry_cnt unchanged.

Source files
------------

// File: rtl/ha_pkg.sv
// rtl/ha_pkg.sv - shared constants, lane type and saturating increment for the half-adder datapath
package ha_pkg;

  localparam int HA_WIDTH = 1;
  localparam int HA_CNT_W = 16;

  typedef logic [HA_WIDTH-1:0] lane_t;

  // Increment v, clamping at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/ha_lane.sv
// rtl/ha_lane.sv - single 1-bit half-adder cell
module ha_lane (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Sum is the parity of the two bits, carry is set only when both are high.
  always_comb begin
    s = a ^ b;
    c = a & b;
  end

endmodule

// File: rtl/ha_df.sv
// rtl/ha_df.sv - WIDTH-lane half adder with live combinational outputs and a valid-qualified register stage (carry counter under HA_DF_CNT_EN)
module ha_df
  import ha_pkg::*;
#(
  parameter int WIDTH = HA_WIDTH,
  parameter int CNT_W = HA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic [WIDTH-1:0] sum_q,
  output logic [WIDTH-1:0] carry_q,
  output logic             out_valid
`ifdef HA_DF_CNT_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] carry_w;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] carry_d;
  logic             out_valid_d;
  logic             out_valid_q;

  // Lanes are independent cells; no carry ever crosses between them.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ha_lane u_lane (
      .a (in1[i]),
      .b (in2[i]),
      .s (sum_w[i]),
      .c (carry_w[i])
    );
  end

  assign sum       = sum_w;
  assign carry     = carry_w;
  assign out_valid = out_valid_q;

  // Capture the lane results only on valid cycles; the valid flag itself follows every edge.
  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d   = sum_w;
      carry_d = carry_w;
    end
  end

  // Output stage; reset drops any in-flight result immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef HA_DF_CNT_EN
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      cnt_inc;

  // Count accepted inputs that produced at least one carry, sticking at all-ones.
  always_comb begin
    cnt_inc = sat_inc(32'(cnt_q), CNT_W);
    cnt_d   = cnt_q;
    if (in_valid && (|carry_w)) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ha_df.sv
// tb/tb_ha_df.sv - randomized and directed checks of ha_df against a lane-arithmetic reference model (HA_DF_CNT_EN enables counter checks)
module tb_ha_df;

  logic       clk;
  logic       rst;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       in_valid;
  logic [7:0] sum;
  logic [7:0] carry;
  logic [7:0] sum_q;
  logic [7:0] carry_q;
  logic       out_valid;
`ifdef HA_DF_CNT_EN
  logic [3:0] carry_cnt;
`endif

  logic       a1;
  logic       b1;
  logic       s1;
  logic       c1;
  logic       sq1;
  logic       cq1;
  logic       ov1;
`ifdef HA_DF_CNT_EN
  logic [15:0] cnt1;
`endif

  int checks;
  int fails;

  logic [7:0] m_sum;
  logic [7:0] m_car;
  logic       m_ov;
  int         m_cnt;

  ha_df #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in1       (in1),
    .in2       (in2),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .sum_q     (sum_q),
    .carry_q   (carry_q),
    .out_valid (out_valid)
`ifdef HA_DF_CNT_EN
    ,
    .carry_cnt (carry_cnt)
`endif
  );

  ha_df #(.WIDTH(1)) dut1 (
    .clk       (1'b0),
    .rst       (1'b0),
    .in1       (a1),
    .in2       (b1),
    .in_valid  (1'b0),
    .sum       (s1),
    .carry     (c1),
    .sum_q     (sq1),
    .carry_q   (cq1),
    .out_valid (ov1)
`ifdef HA_DF_CNT_EN
    ,
    .carry_cnt (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each lane adds two bits arithmetically: low bit of the total is sum, high bit is carry.
  task automatic ref_add(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] s, output logic [7:0] c);
    int t;
    s = '0;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      t = int'(a[i]) + int'(b[i]);
      s[i] = (t % 2) == 1;
      c[i] = (t / 2) == 1;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_sum_q"}, 32'(sum_q), 32'(m_sum));
    chk({tag, "_carry_q"}, 32'(carry_q), 32'(m_car));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_ov));
`ifdef HA_DF_CNT_EN
    chk({tag, "_carry_cnt"}, 32'(carry_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b, input logic v);
    logic [7:0] es;
    logic [7:0] ec;
    @(negedge clk);
    in1 = a;
    in2 = b;
    in_valid = v;
    #1;
    ref_add(a, b, es, ec);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_carry"}, 32'(carry), 32'(ec));
    @(posedge clk);
    m_ov = v;
    if (v) begin
      m_sum = es;
      m_car = ec;
      if (ec != 0 && m_cnt < 15) m_cnt++;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic model_reset();
    m_sum = '0;
    m_car = '0;
    m_ov  = 1'b0;
    m_cnt = 0;
  endtask

  initial begin
    logic [7:0] es;
    logic [7:0] ec;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [1:0] combo;
    checks = 0;
    fails  = 0;
    rst = 1'b1;
    in1 = '0;
    in2 = '0;
    in_valid = 1'b0;
    a1 = 1'b0;
    b1 = 1'b0;
    model_reset();
    #1;
    check_regs("reset");

    // Single-lane instance with clock/reset/valid tied off: pure combinational truth table.
    for (int k = 0; k < 4; k++) begin
      combo = 2'(k);
      a1 = combo[1];
      b1 = combo[0];
      #5;
      chk("w1_sum", 32'(s1), 32'((int'(combo[1]) + int'(combo[0])) % 2));
      chk("w1_carry", 32'(c1), 32'((int'(combo[1]) + int'(combo[0])) / 2));
      #5;
    end

    @(negedge clk);
    rst = 1'b0;

    step("f0_3c", 8'hF0, 8'h3C, 1'b1);
    chk("f0_3c_const_sum", 32'(sum_q), 32'h0000_00CC);
    chk("f0_3c_const_carry", 32'(carry_q), 32'h0000_0030);

    step("load11", 8'h01, 8'h01, 1'b1);
    step("hold01", 8'h00, 8'h01, 1'b0);
    chk("hold_const_carry", 32'(carry_q), 32'h0000_0001);

    for (int k = 0; k < 30; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      step("rand", ra, rb, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset between edges, with inputs still moving.
    step("pre_rst", 8'hFF, 8'h0F, 1'b1);
    #2;
    rst = 1'b1;
    in1 = 8'hA5;
    in2 = 8'h5A;
    in_valid = 1'b1;
    #1;
    model_reset();
    check_regs("async_rst");
    ref_add(8'hA5, 8'h5A, es, ec);
    chk("rst_comb_sum", 32'(sum), 32'(es));
    chk("rst_comb_carry", 32'(carry), 32'(ec));
    @(posedge clk);
    #1;
    check_regs("rst_held");
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 8'h33, 8'h11, 1'b1);

    // Counter saturation and hold conditions.
    for (int k = 0; k < 20; k++) begin
      step("sat", 8'h01, 8'h01, 1'b1);
    end
    step("no_valid", 8'hFF, 8'hFF, 1'b0);
    step("no_carry", 8'hF0, 8'h0F, 1'b1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
